// File: rtl/shift_engine.sv
// Multi-cycle shift engine: coarse STEP-bit jumps, then 1-bit steps, with busy/done handshake.
// Optional SHIFT_ENGINE_STICKY_EN adds a sticky output that ORs every bit shifted out.
module shift_engine #(
    parameter int WIDTH = 64,
    parameter int STEP  = 8,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
`ifdef SHIFT_ENGINE_STICKY_EN
   ,output logic             sticky
`endif
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        M_LOGIC = 2'b00,
        M_ARITH = 2'b01,
        M_ROT   = 2'b10,
        M_RSVD  = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] STEP_C   = CNT_W'(STEP);

    if (STEP <= 1 || STEP >= WIDTH) begin : g_bad_step
        $error("shift_engine: STEP must satisfy 1 < STEP < WIDTH");
    end
    if (WIDTH < 2 * STEP) begin : g_bad_width
        $error("shift_engine: WIDTH must be >= 2*STEP");
    end
    if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt
        $error("shift_engine: CNT_W too narrow to hold WIDTH");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              dir_q, dir_d;
    mode_e             mode_q, mode_d;
    logic              done_q, done_d;

    logic              use_step;
    int unsigned       sh_amt;
    logic [WIDTH-1:0]  shl_val;
    logic [WIDTH-1:0]  shr_val;
    logic [WIDTH-1:0]  asr_val;
    logic [WIDTH-1:0]  rol_val;
    logic [WIDTH-1:0]  ror_val;
    logic [WIDTH-1:0]  step_val;
    logic              lost_hi;
    logic              lost_lo;
    logic              step_lost;

    // One shift step of either STEP or 1 bit, selected from the latched dir/mode.
    always_comb begin
        use_step = (rem_q >= STEP_C);
        sh_amt   = use_step ? STEP : 1;
        shl_val  = q_q << sh_amt;
        shr_val  = q_q >> sh_amt;
        asr_val  = $unsigned($signed(q_q) >>> sh_amt);
        rol_val  = (q_q << sh_amt) | (q_q >> (WIDTH - sh_amt));
        ror_val  = (q_q >> sh_amt) | (q_q << (WIDTH - sh_amt));
        lost_hi  = |(q_q >> (WIDTH - sh_amt));
        lost_lo  = |(q_q & ~(ALL_ONES << sh_amt));

        step_val  = dir_q ? shr_val : shl_val;
        step_lost = dir_q ? lost_lo : lost_hi;
        case (mode_q)
            M_ARITH: step_val = dir_q ? asr_val : shl_val;
            M_ROT: begin
                step_val  = dir_q ? ror_val : rol_val;
                step_lost = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef SHIFT_ENGINE_STICKY_EN
    logic sticky_q, sticky_d;
`endif

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
`ifdef SHIFT_ENGINE_STICKY_EN
        sticky_d = sticky_q;
`endif

        if (load) begin
            q_d     = data;
            state_d = ST_IDLE;
            rem_d   = '0;
`ifdef SHIFT_ENGINE_STICKY_EN
            sticky_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
`ifdef SHIFT_ENGINE_STICKY_EN
                        sticky_d = 1'b0;
`endif
                        if (count != '0) begin
                            dir_d   = dir;
                            mode_d  = mode_e'(mode);
                            rem_d   = count;
                            state_d = ST_SHIFT;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    q_d   = step_val;
                    rem_d = use_step ? (rem_q - STEP_C) : (rem_q - CNT_W'(1));
`ifdef SHIFT_ENGINE_STICKY_EN
                    sticky_d = sticky_q | step_lost;
`endif
                    if (rem_d == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= M_LOGIC;
            done_q  <= 1'b0;
`ifdef SHIFT_ENGINE_STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
`ifdef SHIFT_ENGINE_STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    assign q    = q_q;
    assign busy = (state_q == ST_SHIFT);
    assign done = done_q;
`ifdef SHIFT_ENGINE_STICKY_EN
    assign sticky = sticky_q;
`endif

`ifndef SHIFT_ENGINE_STICKY_EN
    logic unused_lost;
    assign unused_lost = step_lost;
`endif

endmodule

// File: tb/tb_shift_engine.sv
// Directed self-checking bench for shift_engine (WIDTH=64, STEP=8, CNT_W=7).
module tb_shift_engine;

    logic        clk = 1'b0;
    logic        resetn;
    logic        load;
    logic [63:0] data;
    logic        start;
    logic        dir;
    logic [1:0]  mode;
    logic [6:0]  count;
    logic [63:0] q;
    logic        busy;
    logic        done;
`ifdef SHIFT_ENGINE_STICKY_EN
    logic        sticky;
`endif

    int checks   = 0;
    int failures = 0;

    shift_engine #(.WIDTH(64), .STEP(8), .CNT_W(7)) dut (
        .clk    (clk),
        .resetn (resetn),
        .load   (load),
        .data   (data),
        .start  (start),
        .dir    (dir),
        .mode   (mode),
        .count  (count),
        .q      (q),
        .busy   (busy),
        .done   (done)
`ifdef SHIFT_ENGINE_STICKY_EN
       ,.sticky (sticky)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [63:0] v);
        load = 1'b1;
        data = v;
        tick();
        load = 1'b0;
    endtask

    // Issues one request, scrambles the request inputs afterwards, and waits for done.
    task automatic do_shift(input string tag, input logic d, input logic [1:0] m,
                            input logic [6:0] n, input logic [63:0] exp_q,
                            input int exp_c, input logic exp_sticky);
        logic [63:0] q0;
        int          cyc;
        logic        overlap;
        logic        busy_drop;
        q0    = q;
        start = 1'b1;
        dir   = d;
        mode  = m;
        count = n;
        tick();
        start = 1'b0;
        dir   = ~d;
        mode  = 2'b11;
        count = 7'd5;
        chk({tag, "_q_hold"}, q, q0);
        chk({tag, "_busy_on"}, {63'd0, busy}, 64'd1);
        cyc       = 0;
        overlap   = 1'b0;
        busy_drop = 1'b0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
            if (done && busy) overlap = 1'b1;
            if (!done && !busy) busy_drop = 1'b1;
        end
        chk({tag, "_cycles"}, 64'(cyc), 64'(exp_c));
        chk({tag, "_q"}, q, exp_q);
        chk({tag, "_overlap"}, {63'd0, overlap}, 64'd0);
        chk({tag, "_busy_drop"}, {63'd0, busy_drop}, 64'd0);
`ifdef SHIFT_ENGINE_STICKY_EN
        chk({tag, "_sticky"}, {63'd0, sticky}, {63'd0, exp_sticky});
`else
        if (exp_sticky === 1'bx) $display("note: unexpected sticky expectation");
`endif
        tick();
        chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        chk({tag, "_busy_off"}, {63'd0, busy}, 64'd0);
        chk({tag, "_q_stable"}, q, exp_q);
    endtask

    initial begin
        logic seen_done;
        resetn = 1'b0;
        load   = 1'b1;
        data   = 64'hFFFF_0000_FFFF_0000;
        start  = 1'b1;
        dir    = 1'b0;
        mode   = 2'b00;
        count  = 7'd0;
        tick();
        tick();
        chk("reset_q", q, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        resetn = 1'b1;
        load   = 1'b0;
        start  = 1'b0;

        do_load(64'h8000_0000_0000_0001);
        do_shift("asr10", 1'b1, 2'b01, 7'd10, 64'hFFE0_0000_0000_0000, 3, 1'b1);

        do_load(64'h0123_4567_89AB_CDEF);
        do_shift("rol4", 1'b0, 2'b10, 7'd4, 64'h1234_5678_9ABC_DEF0, 4, 1'b0);

        do_load(64'hFFFF_FFFF_FFFF_FFFF);
        do_shift("lsl64", 1'b0, 2'b00, 7'd64, 64'd0, 8, 1'b1);

        do_load(64'h8000_0000_0000_0001);
        do_shift("asr70", 1'b1, 2'b01, 7'd70, 64'hFFFF_FFFF_FFFF_FFFF, 14, 1'b1);

        do_load(64'h0123_4567_89AB_CDEF);
        do_shift("ror64", 1'b1, 2'b10, 7'd64, 64'h0123_4567_89AB_CDEF, 8, 1'b0);

        do_load(64'h0000_0000_0000_00F0);
        do_shift("lsr9_rsvd", 1'b1, 2'b11, 7'd9, 64'd0, 2, 1'b1);

        // Zero-count request completes immediately without going busy.
        do_load(64'h0000_0000_0000_DEAD);
        start = 1'b1;
        count = 7'd0;
        tick();
        start = 1'b0;
        chk("zero_busy", {63'd0, busy}, 64'd0);
        chk("zero_done", {63'd0, done}, 64'd1);
        chk("zero_q", q, 64'h0000_0000_0000_DEAD);
        tick();
        chk("zero_done_clear", {63'd0, done}, 64'd0);

        // Abort by load; a start while busy must be ignored.
        do_load(64'hFFFF_FFFF_FFFF_FFFF);
        start = 1'b1;
        dir   = 1'b1;
        mode  = 2'b00;
        count = 7'd20;
        tick();
        dir   = 1'b0;
        count = 7'd0;
        tick();
        start = 1'b0;
        chk("abort_busy_mid", {63'd0, busy}, 64'd1);
        chk("abort_ignored_start", {63'd0, done}, 64'd0);
        chk("abort_q_mid", q, 64'h00FF_FFFF_FFFF_FFFF);
        load = 1'b1;
        data = 64'h5;
        tick();
        load = 1'b0;
        chk("abort_q", q, 64'h5);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        seen_done = done;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen_done = seen_done | done;
        end
        chk("abort_no_done", {63'd0, seen_done}, 64'd0);
        chk("abort_q_hold", q, 64'h5);

        // Reset in the middle of a shift.
        do_load(64'h1);
        start = 1'b1;
        dir   = 1'b0;
        mode  = 2'b00;
        count = 7'd20;
        tick();
        start = 1'b0;
        tick();
        resetn = 1'b0;
        tick();
        chk("rst_mid_q", q, 64'd0);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_done", {63'd0, done}, 64'd0);
        resetn = 1'b1;
        tick();
        chk("rst_after_done", {63'd0, done}, 64'd0);
        do_load(64'h1);
        do_shift("lsl3_after_rst", 1'b0, 2'b00, 7'd3, 64'h8, 3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
